// File: rtl/arthas_mem_pkg.sv
// Shared definitions for the memory request path.
// Used by the arbiter and by the port controllers.
// Contents:
//   WIDTH_P_ID, WIDTH_MEM_ADDR, WIDTH_REQ - request field widths
//   mem_req_t                             - packed request {p_id, addr}
//   arb_state_t                           - arbiter state encoding
package arthas_mem_pkg;

  localparam int WIDTH_P_ID     = 6;
  localparam int WIDTH_MEM_ADDR = 28;
  localparam int WIDTH_REQ      = WIDTH_P_ID + WIDTH_MEM_ADDR;

  typedef struct packed {
    logic [WIDTH_P_ID-1:0]     p_id;
    logic [WIDTH_MEM_ADDR-1:0] addr;
  } mem_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_ISSUE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_req_arbiter_rr_ptr.sv
// rr_ptr: round-robin pointer register.
// Ports:
//   i_clk - clock
//   i_rst - synchronous active-high reset, clears the pointer to 0
//   i_adv - advance the pointer by one, wrapping after NUM_PC-1
//   o_ptr - current pointer value
module rr_ptr #(
  parameter int NUM_PC = 4,
  parameter int PTR_W  = (NUM_PC > 1) ? $clog2(NUM_PC) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_adv,
  output logic [PTR_W-1:0] o_ptr
);

  logic [PTR_W-1:0] r_ptr;

  // Pointer register: advances on request, wraps at the last port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= {PTR_W{1'b0}};
    end else if (i_adv) begin
      if (r_ptr == PTR_W'(NUM_PC - 1)) begin
        r_ptr <= {PTR_W{1'b0}};
      end else begin
        r_ptr <= r_ptr + PTR_W'(1);
      end
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one memory read port among NUM_PC port controllers.
// A one-hot token visits ports in round-robin order; a returned request is
// forwarded to memory, and read data is steered back by port ID.
// Ports:
//   clk_bus, rst_bus        - clock, synchronous active-high reset
//   tk_en                   - one-hot token to port controllers
//   rd_req_en, rd_req_in    - per-port request strobe and flattened {p_id, addr}
//   mem_req_valid/ready/id/addr - request handshake to memory
//   mem_rsp_valid/id/data   - read response from memory
//   rd_data_mem2pc(_en)     - broadcast read data and one-hot valid per port
//   err                     - sticky protocol error
module mem_req_arbiter #(
  parameter int NUM_PC          = 4,
  parameter int WIDTH_BUS       = 64,
  parameter int WIDTH_P_ID      = arthas_mem_pkg::WIDTH_P_ID,
  parameter int WIDTH_MEM_ADDR  = arthas_mem_pkg::WIDTH_MEM_ADDR,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                         clk_bus,
  input  logic                                         rst_bus,
  output logic [NUM_PC-1:0]                            tk_en,
  input  logic [NUM_PC-1:0]                            rd_req_en,
  input  logic [NUM_PC*(WIDTH_P_ID+WIDTH_MEM_ADDR)-1:0] rd_req_in,
  output logic                                         mem_req_valid,
  input  logic                                         mem_req_ready,
  output logic [WIDTH_P_ID-1:0]                        mem_req_id,
  output logic [WIDTH_MEM_ADDR-1:0]                    mem_req_addr,
  input  logic                                         mem_rsp_valid,
  input  logic [WIDTH_P_ID-1:0]                        mem_rsp_id,
  input  logic [WIDTH_BUS-1:0]                         mem_rsp_data,
  output logic [WIDTH_BUS-1:0]                         rd_data_mem2pc,
  output logic [NUM_PC-1:0]                            rd_data_mem2pc_en,
  output logic                                         err
);
  import arthas_mem_pkg::*;

  localparam int PTR_W = (NUM_PC > 1) ? $clog2(NUM_PC) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int REQ_W = WIDTH_P_ID + WIDTH_MEM_ADDR;

  arb_state_t                r_state;
  arb_state_t                w_next_state;
  logic [PTR_W-1:0]          w_ptr;
  logic [PTR_W-1:0]          r_g;
  logic [OUT_W-1:0]          r_outstanding;
  logic [NUM_PC-1:0]         r_tk_en;
  logic                      r_mem_req_valid;
  logic [WIDTH_P_ID-1:0]     r_mem_req_id;
  logic [WIDTH_MEM_ADDR-1:0] r_mem_req_addr;
  logic [WIDTH_BUS-1:0]      r_rd_data;
  logic [NUM_PC-1:0]         r_rd_data_en;
  logic                      r_err;

  mem_req_t                  w_sel_req;
  logic                      w_sel_en;
  logic                      w_id_ok;
  logic [NUM_PC-1:0]         w_g_onehot;
  logic                      w_stray_req;
  logic                      w_hs;
  logic                      w_rsp_ok;
  logic                      w_rsp_dec;
  logic                      w_can_grant;
  logic                      w_err_set;

  // The pointer only moves when a granted slot is resolved in WAIT; at that
  // point it still equals the latched grant, so advancing it yields g+1.
  rr_ptr #(.NUM_PC(NUM_PC), .PTR_W(PTR_W)) u_rr_ptr (
    .i_clk (clk_bus),
    .i_rst (rst_bus),
    .i_adv (r_state == ARB_WAIT),
    .o_ptr (w_ptr)
  );

  assign w_sel_req   = rd_req_in[int'(r_g)*REQ_W +: REQ_W];
  assign w_sel_en    = rd_req_en[r_g];
  assign w_id_ok     = (w_sel_req.p_id == WIDTH_P_ID'(r_g));
  assign w_g_onehot  = NUM_PC'(1) << r_g;
  // Only the granted port may strobe, and only while its slot is open.
  assign w_stray_req = (r_state == ARB_WAIT) ? |(rd_req_en & ~w_g_onehot) : |rd_req_en;
  assign w_hs        = r_mem_req_valid & mem_req_ready;
  assign w_rsp_ok    = mem_rsp_valid & (mem_rsp_id < WIDTH_P_ID'(NUM_PC));
  assign w_rsp_dec   = w_rsp_ok & (r_outstanding != OUT_W'(0));
  assign w_can_grant = (r_outstanding < OUT_W'(MAX_OUTSTANDING));
  assign w_err_set   = w_stray_req
                     | ((r_state == ARB_WAIT) & w_sel_en & ~w_id_ok)
                     | (mem_rsp_valid & ~w_rsp_ok)
                     | (w_rsp_ok & (r_outstanding == OUT_W'(0)));

  // Next-state decode for the grant/issue sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_can_grant) w_next_state = ARB_GRANT;
        else             w_next_state = ARB_IDLE;
      end
      ARB_GRANT: w_next_state = ARB_WAIT;
      ARB_WAIT: begin
        if (w_sel_en && w_id_ok) w_next_state = ARB_ISSUE;
        else                     w_next_state = ARB_IDLE;
      end
      ARB_ISSUE: begin
        if (mem_req_ready) w_next_state = ARB_IDLE;
        else               w_next_state = ARB_ISSUE;
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_bus) begin
    if (rst_bus) r_state <= ARB_IDLE;
    else         r_state <= w_next_state;
  end

  // Registered outputs, grant latch, outstanding counter and error flag.
  always_ff @(posedge clk_bus) begin
    if (rst_bus) begin
      r_tk_en         <= {NUM_PC{1'b0}};
      r_g             <= {PTR_W{1'b0}};
      r_outstanding   <= {OUT_W{1'b0}};
      r_mem_req_valid <= 1'b0;
      r_mem_req_id    <= {WIDTH_P_ID{1'b0}};
      r_mem_req_addr  <= {WIDTH_MEM_ADDR{1'b0}};
      r_rd_data       <= {WIDTH_BUS{1'b0}};
      r_rd_data_en    <= {NUM_PC{1'b0}};
      r_err           <= 1'b0;
    end else begin
      // Token is raised for exactly the GRANT cycle.
      if (r_state == ARB_IDLE && w_can_grant) r_tk_en <= NUM_PC'(1) << w_ptr;
      else                                    r_tk_en <= {NUM_PC{1'b0}};

      if (r_state == ARB_GRANT) r_g <= w_ptr;
      else                      r_g <= r_g;

      if (r_state == ARB_WAIT && w_sel_en && w_id_ok) begin
        r_mem_req_valid <= 1'b1;
        r_mem_req_id    <= w_sel_req.p_id;
        r_mem_req_addr  <= w_sel_req.addr;
      end else if (w_hs) begin
        r_mem_req_valid <= 1'b0;
      end else begin
        r_mem_req_valid <= r_mem_req_valid;
      end

      case ({w_hs, w_rsp_dec})
        2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase

      if (w_rsp_ok) begin
        r_rd_data    <= mem_rsp_data;
        r_rd_data_en <= NUM_PC'(1) << mem_rsp_id;
      end else begin
        r_rd_data_en <= {NUM_PC{1'b0}};
      end

      r_err <= r_err | w_err_set;
    end
  end

  assign tk_en             = r_tk_en;
  assign mem_req_valid     = r_mem_req_valid;
  assign mem_req_id        = r_mem_req_id;
  assign mem_req_addr      = r_mem_req_addr;
  assign rd_data_mem2pc    = r_rd_data;
  assign rd_data_mem2pc_en = r_rd_data_en;
  assign err               = r_err;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a simple port-controller responder.
module tb_mem_req_arbiter;

  logic         clk_bus = 1'b0;
  logic         rst_bus;
  logic [3:0]   tk_en;
  logic [3:0]   rd_req_en;
  logic [135:0] rd_req_in;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [5:0]   mem_req_id;
  logic [27:0]  mem_req_addr;
  logic         mem_rsp_valid;
  logic [5:0]   mem_rsp_id;
  logic [63:0]  mem_rsp_data;
  logic [63:0]  rd_data_mem2pc;
  logic [3:0]   rd_data_mem2pc_en;
  logic         err;

  logic [3:0]   pc_active;
  logic [3:0]   stray;
  logic [3:0]   prev_tk;
  logic [5:0]   pc_pid  [4];
  logic [27:0]  pc_addr [4];

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  mem_req_arbiter dut (
    .clk_bus           (clk_bus),
    .rst_bus           (rst_bus),
    .tk_en             (tk_en),
    .rd_req_en         (rd_req_en),
    .rd_req_in         (rd_req_in),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_id        (mem_req_id),
    .mem_req_addr      (mem_req_addr),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_id        (mem_rsp_id),
    .mem_rsp_data      (mem_rsp_data),
    .rd_data_mem2pc    (rd_data_mem2pc),
    .rd_data_mem2pc_en (rd_data_mem2pc_en),
    .err               (err)
  );

  always #5 clk_bus = ~clk_bus;

  always_comb begin
    rd_req_in = '0;
    for (int i = 0; i < 4; i++) rd_req_in[i*34 +: 34] = {pc_pid[i], pc_addr[i]};
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One bus cycle; ports answer the token seen in the previous cycle.
  task automatic tick();
    @(posedge clk_bus);
    #1;
    rd_req_en = (prev_tk & pc_active) | stray;
    prev_tk   = tk_en;
  endtask

  task automatic wait_tk(input int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (tk_en == 4'b0000 && cnt < budget);
  endtask

  task automatic do_reset();
    rst_bus   = 1'b1;
    rd_req_en = 4'b0000;
    prev_tk   = 4'b0000;
    stray     = 4'b0000;
    pc_active = 4'b0000;
    tick();
    tick();
    rst_bus = 1'b0;
  endtask

  initial begin
    rst_bus = 1'b1; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    mem_rsp_id = 6'd0; mem_rsp_data = 64'd0; stray = 4'b0000;
    pc_active = 4'b0000; prev_tk = 4'b0000; rd_req_en = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      pc_pid[i]  = 6'(i);
      pc_addr[i] = 28'h0001000 + 28'(i);
    end

    // Reset state
    do_reset();
    check_eq("rst_tk_en", 64'(tk_en), 64'h0);
    check_eq("rst_valid", 64'(mem_req_valid), 64'h0);
    check_eq("rst_id", 64'(mem_req_id), 64'h0);
    check_eq("rst_addr", 64'(mem_req_addr), 64'h0);
    check_eq("rst_data", rd_data_mem2pc, 64'h0);
    check_eq("rst_data_en", 64'(rd_data_mem2pc_en), 64'h0);
    check_eq("rst_err", 64'(err), 64'h0);

    // Single request from port 2, empty ports 0 and 1 cost 3 cycles each
    do_reset();
    pc_active = 4'b0100; pc_pid[2] = 6'd2; pc_addr[2] = 28'h0000100;
    mem_req_ready = 1'b1;
    wait_tk(20, n); check_eq("sr_tk0", 64'(tk_en), 64'h1); check_eq("sr_gap0", 64'(n), 64'd1);
    wait_tk(20, n); check_eq("sr_tk1", 64'(tk_en), 64'h2); check_eq("sr_gap1", 64'(n), 64'd3);
    wait_tk(20, n); check_eq("sr_tk2", 64'(tk_en), 64'h4); check_eq("sr_gap2", 64'(n), 64'd3);
    tick(); check_eq("sr_valid_t1", 64'(mem_req_valid), 64'h0);
    tick(); check_eq("sr_valid_t2", 64'(mem_req_valid), 64'h1);
    check_eq("sr_id", 64'(mem_req_id), 64'd2);
    check_eq("sr_addr", 64'(mem_req_addr), 64'h0000100);
    tick(); check_eq("sr_valid_t3", 64'(mem_req_valid), 64'h0);
    check_eq("sr_outstanding", 64'(dut.r_outstanding), 64'd1);
    wait_tk(20, n); check_eq("sr_tk3", 64'(tk_en), 64'h8); check_eq("sr_gap3", 64'(n), 64'd1);
    check_eq("sr_err", 64'(err), 64'h0);

    // Round robin with all ports requesting, then outstanding limit
    do_reset();
    pc_pid[2] = 6'd2; pc_addr[2] = 28'h0001002;
    pc_active = 4'b1111; mem_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_tk(20, n);
      check_eq("rr_tk", 64'(tk_en), 64'(4'b0001 << k));
      check_eq("rr_gap", 64'(n), (k == 0) ? 64'd1 : 64'd4);
    end
    tick(); tick();
    check_eq("rr_id3", 64'(mem_req_id), 64'd3);
    check_eq("rr_addr3", 64'(mem_req_addr), 64'h0001003);
    wait_tk(10, n);
    check_eq("lim_no_tk", 64'(tk_en), 64'h0);
    check_eq("lim_outstanding", 64'(dut.r_outstanding), 64'd4);
    mem_rsp_valid = 1'b1; mem_rsp_id = 6'd1; mem_rsp_data = 64'hCAFE_0001_BEEF_0002;
    tick();
    mem_rsp_valid = 1'b0;
    check_eq("lim_rsp_en", 64'(rd_data_mem2pc_en), 64'h2);
    check_eq("lim_rsp_data", rd_data_mem2pc, 64'hCAFE_0001_BEEF_0002);
    check_eq("lim_out_dec", 64'(dut.r_outstanding), 64'd3);
    tick();
    check_eq("lim_en_pulse", 64'(rd_data_mem2pc_en), 64'h0);
    check_eq("lim_regrant", 64'(tk_en), 64'h1);
    tick(); tick();
    check_eq("sim_valid", 64'(mem_req_valid), 64'h1);
    mem_rsp_valid = 1'b1; mem_rsp_id = 6'd3; mem_rsp_data = 64'h0000_0000_0000_0033;
    tick();
    mem_rsp_valid = 1'b0;
    check_eq("sim_outstanding", 64'(dut.r_outstanding), 64'd3);
    check_eq("sim_rsp_en", 64'(rd_data_mem2pc_en), 64'h8);
    check_eq("sim_valid_drop", 64'(mem_req_valid), 64'h0);
    check_eq("rr_err", 64'(err), 64'h0);

    // Backpressure: ready low for 5 cycles
    do_reset();
    pc_active = 4'b0001; mem_req_ready = 1'b0;
    wait_tk(20, n); check_eq("bp_tk", 64'(tk_en), 64'h1);
    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      check_eq("bp_valid", 64'(mem_req_valid), 64'h1);
      check_eq("bp_id", 64'(mem_req_id), 64'd0);
      check_eq("bp_addr", 64'(mem_req_addr), 64'h0001000);
      check_eq("bp_no_tk", 64'(tk_en), 64'h0);
      if (i == 5) mem_req_ready = 1'b1;
      tick();
    end
    check_eq("bp_released", 64'(mem_req_valid), 64'h0);
    check_eq("bp_outstanding", 64'(dut.r_outstanding), 64'd1);

    // Response with an out-of-range id
    do_reset();
    mem_rsp_valid = 1'b1; mem_rsp_id = 6'd5; mem_rsp_data = 64'h55;
    tick();
    mem_rsp_valid = 1'b0;
    check_eq("bad_id_en", 64'(rd_data_mem2pc_en), 64'h0);
    check_eq("bad_id_err", 64'(err), 64'h1);

    // Response while nothing is outstanding
    do_reset();
    check_eq("zero_err_pre", 64'(err), 64'h0);
    mem_rsp_valid = 1'b1; mem_rsp_id = 6'd0; mem_rsp_data = 64'h77;
    tick();
    mem_rsp_valid = 1'b0;
    check_eq("zero_outstanding", 64'(dut.r_outstanding), 64'd0);
    check_eq("zero_err", 64'(err), 64'h1);

    // Strobe from a port that holds no token
    do_reset();
    stray = 4'b1000;
    tick();
    stray = 4'b0000;
    check_eq("stray_err_pre", 64'(err), 64'h0);
    tick();
    check_eq("stray_err", 64'(err), 64'h1);

    // Port 1 answers with the wrong p_id
    do_reset();
    pc_active = 4'b0010; pc_pid[1] = 6'd3; mem_req_ready = 1'b1;
    wait_tk(20, n);
    wait_tk(20, n); check_eq("pid_tk", 64'(tk_en), 64'h2);
    tick(); check_eq("pid_err_pre", 64'(err), 64'h0);
    tick();
    check_eq("pid_dropped", 64'(mem_req_valid), 64'h0);
    check_eq("pid_err", 64'(err), 64'h1);
    wait_tk(20, n);
    check_eq("pid_next_tk", 64'(tk_en), 64'h4);
    check_eq("pid_next_gap", 64'(n), 64'd1);
    pc_pid[1] = 6'd1;

    // Reset while a request is held in ISSUE
    do_reset();
    pc_active = 4'b0100; pc_pid[2] = 6'd2; pc_addr[2] = 28'h0ABCDEF; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_id = 6'd0; mem_rsp_data = 64'h1234;
    tick();
    mem_rsp_valid = 1'b0;
    n = 0;
    while (mem_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_eq("mid_valid", 64'(mem_req_valid), 64'h1);
    check_eq("mid_addr", 64'(mem_req_addr), 64'h0ABCDEF);
    rst_bus = 1'b1;
    tick();
    check_eq("mid_tk_en", 64'(tk_en), 64'h0);
    check_eq("mid_rst_valid", 64'(mem_req_valid), 64'h0);
    check_eq("mid_rst_id", 64'(mem_req_id), 64'h0);
    check_eq("mid_rst_addr", 64'(mem_req_addr), 64'h0);
    check_eq("mid_rst_data", rd_data_mem2pc, 64'h0);
    check_eq("mid_rst_data_en", 64'(rd_data_mem2pc_en), 64'h0);
    check_eq("mid_rst_err", 64'(err), 64'h0);
    check_eq("mid_rst_outstanding", 64'(dut.r_outstanding), 64'd0);
    tick();
    rst_bus = 1'b0;
    wait_tk(5, n);
    check_eq("mid_first_tk", 64'(tk_en), 64'h1);
    check_eq("mid_first_gap", 64'(n), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
